video_timing_gen: RTL

//  Parametrised raster timing generator, next generation of the fixed 5 MHz sync block.

---
 rtl/video_timing_gen.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator. Horizontal and vertical counters
// advance on the pixel clock-enable. Blank, sync, inhibit and mirrored
// (cocktail-flip) counts are decoded from the *next* count value. They are
// registered in the same clock as the counters, so every output matches the
// count it is presented with.
//
// Optional feature macro: RASTER_IRQ_EN
//   defined   : irq sets when hcnt becomes H_ACTIVE on line irq_line, and
//               clears on irq_ack. Set wins over a simultaneous ack.
//   undefined : irq is tied low; irq_line / irq_ack are ignored.
//
// Ports
//   clk_10M     in  1   system clock
//   reset_n     in  1   asynchronous active-low reset
//   ce_pix      in  1   pixel clock enable, gates all counting
//   flip        in  1   cocktail flip (v_sync polarity, mirrored counts)
//   irq_line    in  VW  raster interrupt compare line (unflipped domain)
//   irq_ack     in  1   one-cycle pulse clearing irq
//   hcnt/vcnt   out     raw counters
//   hcnt_f      out HW  hcnt, or H_ACTIVE-1-hcnt when flipped (valid outside h_blank)
//   vcnt_f      out VW  vcnt, or V_TOTAL-1-vcnt when flipped
//   h_blank, v_blank, h_sync, v_sync, inhibit   decoded windows
//   line_start, frame_start                     one-clk strobes on wrap
//   irq         out 1   raster interrupt level
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_TOTAL   = 326,
  parameter int H_ACTIVE  = 256,
  parameter int HS_START  = 276,
  parameter int HS_END    = 286,
  parameter int V_TOTAL   = 256,
  parameter int VB_START  = 0,
  parameter int VB_END    = 25,
  parameter int VS_START  = 8,
  parameter int VS_END    = 12,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b0,
  parameter int INH_START = 224,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_10M,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic          flip,
  input  logic [VW-1:0] irq_line,
  input  logic          irq_ack,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] hcnt_f,
  output logic [VW-1:0] vcnt_f,
  output logic          h_blank,
  output logic          v_blank,
  output logic          h_sync,
  output logic          v_sync,
  output logic          inhibit,
  output logic          line_start,
  output logic          frame_start,
  output logic          irq
);

  // Elaboration-time parameter sanity checks.
  generate
    if (H_ACTIVE >= H_TOTAL) begin : g_bad_h_active
      $error("video_timing_gen: H_ACTIVE must be less than H_TOTAL");
    end
    if (HS_END > H_TOTAL) begin : g_bad_hs_end
      $error("video_timing_gen: HS_END must not exceed H_TOTAL");
    end
    if (VS_END > V_TOTAL) begin : g_bad_vs_end
      $error("video_timing_gen: VS_END must not exceed V_TOTAL");
    end
    if (INH_START >= V_TOTAL) begin : g_bad_inh_start
      $error("video_timing_gen: INH_START must be less than V_TOTAL");
    end
  endgenerate

  // [s, e) window; wraps through zero when e < s.
  function automatic logic in_window(int cnt, int s, int e);
    if (e >= s) return (cnt >= s) && (cnt < e);
    return (cnt >= s) || (cnt < e);
  endfunction

  function automatic logic sync_level(logic active, logic pol);
    return active ? pol : ~pol;
  endfunction

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Decoded values for count 0,0 with flip=0, loaded by reset.
  localparam logic H_BLANK_RST = (H_ACTIVE <= 0);
  localparam logic V_BLANK_RST = in_window(0, VB_START, VB_END);
  localparam logic H_SYNC_RST  = sync_level(in_window(0, HS_START, HS_END), HS_POL);
  localparam logic V_SYNC_RST  = sync_level(in_window(0, VS_START, VS_END), VS_POL);
  localparam logic INHIBIT_RST = (INH_START <= 0);

  logic          h_wrap;
  logic          v_wrap;
  logic [HW-1:0] hcnt_nxt;
  logic [VW-1:0] vcnt_nxt;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    h_wrap   = (hcnt == H_LAST);
    v_wrap   = (vcnt == V_LAST);
    hcnt_nxt = h_wrap ? '0 : hcnt + HW'(1);
    vcnt_nxt = vcnt;
    if (h_wrap) vcnt_nxt = v_wrap ? '0 : vcnt + VW'(1);
  end

  // Decodes of the count about to be loaded, so outputs line up with it.
  logic          h_blank_nxt;
  logic          v_blank_nxt;
  logic          h_sync_nxt;
  logic          v_sync_nxt;
  logic          inhibit_nxt;
  logic [HW-1:0] hcnt_f_nxt;
  logic [VW-1:0] vcnt_f_nxt;

  assign h_blank_nxt = (int'(hcnt_nxt) >= H_ACTIVE);
  assign v_blank_nxt = in_window(int'(vcnt_nxt), VB_START, VB_END);
  assign h_sync_nxt  = sync_level(in_window(int'(hcnt_nxt), HS_START, HS_END), HS_POL);
  assign v_sync_nxt  = sync_level(in_window(int'(vcnt_nxt), VS_START, VS_END), VS_POL ^ flip);
  assign inhibit_nxt = (int'(vcnt_nxt) >= INH_START);
  // Mirrored counts wrap modulo the counter width inside the blank region.
  assign hcnt_f_nxt  = flip ? HW'(H_ACTIVE - 1 - int'(hcnt_nxt)) : hcnt_nxt;
  assign vcnt_f_nxt  = flip ? VW'(V_TOTAL - 1 - int'(vcnt_nxt)) : vcnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_10M or negedge reset_n) begin
    if (!reset_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hcnt_f      <= '0;
      vcnt_f      <= '0;
      h_blank     <= H_BLANK_RST;
      v_blank     <= V_BLANK_RST;
      h_sync      <= H_SYNC_RST;
      v_sync      <= V_SYNC_RST;
      inhibit     <= INHIBIT_RST;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes last exactly one clk, whether or not ce_pix follows.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce_pix) begin
        hcnt        <= hcnt_nxt;
        vcnt        <= vcnt_nxt;
        hcnt_f      <= hcnt_f_nxt;
        vcnt_f      <= vcnt_f_nxt;
        h_blank     <= h_blank_nxt;
        v_blank     <= v_blank_nxt;
        h_sync      <= h_sync_nxt;
        v_sync      <= v_sync_nxt;
        inhibit     <= inhibit_nxt;
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

`ifdef RASTER_IRQ_EN
  logic irq_set;

  assign irq_set = ce_pix && (int'(hcnt_nxt) == H_ACTIVE) && (vcnt_nxt == irq_line);

  always_ff @(posedge clk_10M or negedge reset_n) begin
    if (!reset_n)     irq <= 1'b0;
    else if (irq_set) irq <= 1'b1;   // set wins over a coincident ack
    else if (irq_ack) irq <= 1'b0;
  end
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{irq_line, irq_ack};
  assign irq               = 1'b0;
`endif

endmodule
